// File: rtl/mod12_wrap_monitor.sv
// mod12_wrap_monitor
// Watches a mod-12 loadable up/down counter and classifies each sampled
// transition: normal step, wrap-up, wrap-down, load jump, hold or illegal.
// Keeps a half-day toggle and a running wrap total, and registers the last
// legal count as two BCD digits for the display stage.
// Build option: define WRAP_SAT_EN to make wrap_total saturate at all-ones
// instead of rolling over.
module mod12_wrap_monitor #(
  parameter int WRAP_W  = 8,
  parameter int MAX_VAL = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              mode,
  input  logic [3:0]        count_in,
  input  logic              clear_fault,
  output logic              wrap_up,
  output logic              wrap_down,
  output logic              jump,
  output logic              half_day,
  output logic [WRAP_W-1:0] wrap_total,
  output logic [3:0]        tens,
  output logic [3:0]        ones,
  output logic              fault
);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [3:0] MAXV = MAX_VAL[3:0];

  logic [1:0]        state;
  logic [3:0]        prev;
  logic              legal;
  logic              up_wrap, dn_wrap, step_ok, hold;
  logic [3:0]        bcd_tens, bcd_ones;
  logic [WRAP_W-1:0] wrap_next;

  // Classify the incoming sample against the previous legal value.
  // A step that would leave the legal range (12+1, 0-1) can never match a
  // legal count_in, so the boundary cases fall out as jump or wrap.
  always_comb begin
    legal   = (count_in <= MAXV);
    up_wrap = (prev == MAXV) && (count_in == 4'd0) && mode;
    dn_wrap = (prev == 4'd0) && (count_in == MAXV) && !mode;
    step_ok = mode ? (count_in == prev + 4'd1) : (count_in == prev - 4'd1);
    hold    = (count_in == prev);
  end

  // BCD split of the sampled count for the display stage.
  always_comb begin
    if (count_in >= 4'd10) begin
      bcd_tens = 4'd1;
      bcd_ones = count_in - 4'd10;
    end else begin
      bcd_tens = 4'd0;
      bcd_ones = count_in;
    end
  end

  // Next wrap total: saturating or modulo, depending on build option.
  always_comb begin
`ifdef WRAP_SAT_EN
    wrap_next = (&wrap_total) ? wrap_total : wrap_total + WRAP_W'(1);
`else
    wrap_next = wrap_total + WRAP_W'(1);
`endif
  end

  // Monitor FSM and registered outputs; pulses default low every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      prev       <= 4'd0;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      jump       <= 1'b0;
      half_day   <= 1'b0;
      wrap_total <= '0;
      tens       <= 4'd0;
      ones       <= 4'd0;
      fault      <= 1'b0;
    end else begin
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      jump      <= 1'b0;
      case (state)
        INIT: begin
          if (sample_en) begin
            if (legal) begin
              prev  <= count_in;
              tens  <= bcd_tens;
              ones  <= bcd_ones;
              state <= TRACK;
            end else begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end
        end
        TRACK: begin
          if (sample_en) begin
            if (!legal) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              prev <= count_in;
              tens <= bcd_tens;
              ones <= bcd_ones;
              if (up_wrap) begin
                wrap_up    <= 1'b1;
                half_day   <= ~half_day;
                wrap_total <= wrap_next;
              end else if (dn_wrap) begin
                wrap_down  <= 1'b1;
                half_day   <= ~half_day;
                wrap_total <= wrap_next;
              end else if (!(step_ok || hold)) begin
                jump <= 1'b1;
              end
            end
          end
        end
        FAULT: begin
          // Samples are dropped here; clear wins even if a sample arrives.
          if (clear_fault) begin
            fault <= 1'b0;
            state <= INIT;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod12_wrap_monitor.sv
// Directed bench for mod12_wrap_monitor. Two instances share the stimulus:
// the default 8-bit wrap counter and a 2-bit one for the rollover/saturate
// check. Expected outputs are queued when a step is driven and popped and
// compared one clock later, when the registered outputs reflect that step.
module tb_mod12_wrap_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       mode;
  logic [3:0] count_in;
  logic       clear_fault;

  logic       wrap_up, wrap_down, jump, half_day, fault;
  logic [7:0] wrap_total;
  logic [3:0] tens, ones;

  logic       wrap_up2, wrap_down2, jump2, half_day2, fault2;
  logic [1:0] wrap_total2;
  logic [3:0] tens2, ones2;

  typedef struct {
    string      tag;
    logic       wu, wd, jp, hd;
    logic [7:0] wt;
    logic [3:0] tn, on;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  mod12_wrap_monitor #(.WRAP_W(8), .MAX_VAL(12)) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .mode(mode),
    .count_in(count_in), .clear_fault(clear_fault),
    .wrap_up(wrap_up), .wrap_down(wrap_down), .jump(jump),
    .half_day(half_day), .wrap_total(wrap_total),
    .tens(tens), .ones(ones), .fault(fault)
  );

  mod12_wrap_monitor #(.WRAP_W(2), .MAX_VAL(12)) dut2 (
    .clock(clock), .reset(reset), .sample_en(sample_en), .mode(mode),
    .count_in(count_in), .clear_fault(clear_fault),
    .wrap_up(wrap_up2), .wrap_down(wrap_down2), .jump(jump2),
    .half_day(half_day2), .wrap_total(wrap_total2),
    .tens(tens2), .ones(ones2), .fault(fault2)
  );

  // Expected 2-bit wrap total derived from the expected wrap count.
  function automatic logic [1:0] w2(input logic [7:0] wt);
`ifdef WRAP_SAT_EN
    return (wt > 8'd3) ? 2'd3 : wt[1:0];
`else
    return wt[1:0];
`endif
  endfunction

  task automatic chk(input string tag, input string fld,
                     input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic en,
                      input logic md, input logic [3:0] cnt, input logic clr,
                      input logic wu, input logic wd, input logic jp,
                      input logic hd, input logic [7:0] wt,
                      input logic [3:0] tn, input logic [3:0] on,
                      input logic ft);
    exp_t e;
    reset       = rst;
    sample_en   = en;
    mode        = md;
    count_in    = cnt;
    clear_fault = clr;
    e.tag = tag; e.wu = wu; e.wd = wd; e.jp = jp; e.hd = hd;
    e.wt = wt; e.tn = tn; e.on = on; e.ft = ft;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk(e.tag, "wrap_up",    {7'd0, wrap_up},   {7'd0, e.wu});
    chk(e.tag, "wrap_down",  {7'd0, wrap_down}, {7'd0, e.wd});
    chk(e.tag, "jump",       {7'd0, jump},      {7'd0, e.jp});
    chk(e.tag, "half_day",   {7'd0, half_day},  {7'd0, e.hd});
    chk(e.tag, "wrap_total", wrap_total,        e.wt);
    chk(e.tag, "tens",       {4'd0, tens},      {4'd0, e.tn});
    chk(e.tag, "ones",       {4'd0, ones},      {4'd0, e.on});
    chk(e.tag, "fault",      {7'd0, fault},     {7'd0, e.ft});
    chk(e.tag, "wrap_total_w2", {6'd0, wrap_total2}, {6'd0, w2(e.wt)});
    chk(e.tag, "half_day_w2",   {7'd0, half_day2},   {7'd0, e.hd});
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; mode = 1'b0; count_in = 4'd0; clear_fault = 1'b0;
    //         tag        rst en md cnt  clr  wu wd jp hd wt  tn on ft
    step("reset",        1, 0, 0, 4'd0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // Up run into a wrap.
    step("seed10",       0, 1, 1, 4'd10, 0,  0, 0, 0, 0, 0, 1, 0, 0);
    step("up11",         0, 1, 1, 4'd11, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    step("up12",         0, 1, 1, 4'd12, 0,  0, 0, 0, 0, 0, 1, 2, 0);
    step("wrapup",       0, 1, 1, 4'd0,  0,  1, 0, 0, 1, 1, 0, 0, 0);
    step("idle1",        0, 0, 1, 4'd5,  0,  0, 0, 0, 1, 1, 0, 0, 0);
    // Down wrap from prev=1.
    step("up1",          0, 1, 1, 4'd1,  0,  0, 0, 0, 1, 1, 0, 1, 0);
    step("dn0",          0, 1, 0, 4'd0,  0,  0, 0, 0, 1, 1, 0, 0, 0);
    step("wrapdn",       0, 1, 0, 4'd12, 0,  0, 1, 0, 0, 2, 1, 2, 0);
    step("idle2",        0, 0, 0, 4'd0,  0,  0, 0, 0, 0, 2, 1, 2, 0);
    // Loads, hold, step against mode, wrap pattern with wrong mode.
    step("load3",        0, 1, 0, 4'd3,  0,  0, 0, 1, 0, 2, 0, 3, 0);
    step("jump9",        0, 1, 1, 4'd9,  0,  0, 0, 1, 0, 2, 0, 9, 0);
    step("hold9",        0, 1, 1, 4'd9,  0,  0, 0, 0, 0, 2, 0, 9, 0);
    step("against",      0, 1, 1, 4'd8,  0,  0, 0, 1, 0, 2, 0, 8, 0);
    step("load12",       0, 1, 1, 4'd12, 0,  0, 0, 1, 0, 2, 1, 2, 0);
    step("wrongwrap",    0, 1, 0, 4'd0,  0,  0, 0, 1, 0, 2, 0, 0, 0);
    // Fault entry, ignored samples, clear beats sample, re-seed.
    step("illegal14",    0, 1, 1, 4'd14, 0,  0, 0, 0, 0, 2, 0, 0, 1);
    step("fltignore",    0, 1, 1, 4'd5,  0,  0, 0, 0, 0, 2, 0, 0, 1);
    step("clrwins",      0, 1, 1, 4'd7,  1,  0, 0, 0, 0, 2, 0, 0, 0);
    step("reseed5",      0, 1, 1, 4'd5,  0,  0, 0, 0, 0, 2, 0, 5, 0);
    step("up6",          0, 1, 1, 4'd6,  0,  0, 0, 0, 0, 2, 0, 6, 0);
    step("clrnofx",      0, 1, 1, 4'd7,  1,  0, 0, 0, 0, 2, 0, 7, 0);
    // Reset in the same cycle as a wrapping sample.
    step("pre12",        0, 1, 1, 4'd12, 0,  0, 0, 1, 0, 2, 1, 2, 0);
    step("rstwrap",      1, 1, 1, 4'd0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
    step("initseed0",    0, 1, 1, 4'd0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
    // Illegal first sample in INIT, then reset out of FAULT.
    step("rst2",         1, 0, 0, 4'd0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
    step("init13",       0, 1, 1, 4'd13, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    step("rstfault",     1, 0, 0, 4'd0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
    // Five up-wraps: 2-bit total rolls to 1 (or saturates at 3).
    step("seedw",        0, 1, 1, 4'd12, 0,  0, 0, 0, 0, 0, 1, 2, 0);
    for (int k = 1; k <= 5; k++) begin
      step("wrapk",      0, 1, 1, 4'd0,  0,  1, 0, 0, k[0], 8'(k), 0, 0, 0);
      step("reload12",   0, 1, 1, 4'd12, 0,  0, 0, 1, k[0], 8'(k), 1, 2, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
